// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word fetches under a credit limit,
// and buffers responses in an in-order queue that feeds decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST   = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   CREDIT = (CW+1)'(FIFO_DEPTH);
    localparam logic [31:0]   NOP    = 32'h0000_0013;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e        state_q;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   word_q [FIFO_DEPTH];
    logic [31:0]   wpc_q  [FIFO_DEPTH];

    logic        fire, rsp, push, pop;
    logic [31:0] redir_pc;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc[1:0];
    assign redir_pc    = {redirect_pc[31:2], 2'b00};

    assign imem_req = !reset && !redirect_valid
                    && (({1'b0, outstanding_q} + {1'b0, count_q}) < CREDIT);
    assign imem_addr = pc_q;

    assign instr_valid = (count_q != '0) && !redirect_valid;
    assign instr       = instr_valid ? word_q[rd_ptr_q] : NOP;
    assign instr_pc    = (count_q != '0) ? wpc_q[rd_ptr_q] : rsp_pc_q;
    assign opcode      = instr[6:0];

    always_comb begin
        fire = imem_req && imem_gnt;
        rsp  = imem_rvalid && (outstanding_q != '0);
        pop  = instr_valid && instr_ready;
        push = rsp && (state_q == RUN) && !redirect_valid;

        outstanding_d = outstanding_q + CW'(fire) - CW'(rsp);
        pc_d          = fire ? pc_q + 32'd4 : pc_q;
        rsp_pc_d      = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        discard_d     = discard_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (pop)
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        if (push)
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);

        if (redirect_valid) begin
            // every response still owed predates the redirect: all stale
            discard_d = outstanding_q - CW'(rsp);
            pc_d      = redir_pc;
            rsp_pc_d  = redir_pc;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
        end else if (rsp && (state_q == FLUSH)) begin
            discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= (discard_d != '0) ? FLUSH : RUN;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr_q] <= imem_rdata;
            wpc_q[wr_ptr_q]  <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model with a grant/response
// schedule and an expected-instruction queue checked on every pop.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [6:0]  opcode;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .opcode(opcode)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] addr; } mreq_t;
    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } rvec_t;

    mreq_t       mq[$];
    logic [63:0] exq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          mem_mode = 0;
    bit          gnt_en, force_rv;
    bit          req_s, fire_s, valid_s, pop_s;
    logic [31:0] addr_s, pc_s, instr_s;
    logic [6:0]  op_s;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (mem_mode == 0) ? 32'h0000_0033 : 32'h0000_0003 + (a << 6);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic cycle();
        logic [63:0] e;
        imem_gnt    = gnt_en;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (force_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h0000_00b3;
        end else if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memw(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        req_s   = imem_req;
        fire_s  = imem_req && imem_gnt;
        valid_s = instr_valid;
        pop_s   = instr_valid && instr_ready;
        addr_s  = imem_addr;
        pc_s    = instr_pc;
        instr_s = instr;
        op_s    = opcode;
        if (reset) begin
            mq.delete();
            exq.delete();
        end else begin
            if (pop_s) begin
                if (exq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got pc %h expected none", pc_s);
                end else begin
                    e = exq.pop_front();
                    chk("sb_instr", instr_s, e[63:32]);
                    chk("sb_pc", pc_s, e[31:0]);
                    chk("sb_opcode", {25'd0, op_s}, {25'd0, e[38:32]});
                end
            end
            if (redirect_valid) exq.delete();
            if (fire_s) begin
                mq.push_back('{cyc + lat, addr_s});
                exq.push_back({memw(addr_s), addr_s});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        redirect_valid = 1'b0;
        repeat (n) cycle();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", instr_pc, RESET_PC);
        chk("rst_opcode", {25'd0, opcode}, 32'h13);
        reset = 1'b0;
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp_pc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (pop_s) got = 1'b1;
        end
        if (got) chk(name, pc_s, exp_pc);
        else flag(name);
    endtask

    rvec_t tbl[4];

    initial begin
        int rel, first, npop, fp, lp, ngnt;
        bit seen;

        tbl[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        tbl[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[2] = '{32'h0000_2001, 32'h0000_2000, 32'h0000_2004};
        tbl[3] = '{32'h0000_07FE, 32'h0000_07FC, 32'h0000_0800};

        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        gnt_en = 1'b1;
        force_rv = 1'b0;

        // boot
        do_reset(3);
        rel = cyc;
        cycle();
        chk("boot_req", {31'd0, req_s}, 32'd1);
        chk("boot_addr", addr_s, RESET_PC);
        first = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            cycle();
            if (valid_s) begin
                first = cyc - 1 - rel;
                chk("boot_pc", pc_s, RESET_PC);
                chk("boot_opcode", {25'd0, op_s}, 32'h33);
            end
        end
        if (first < 0) flag("boot_valid");
        else chk("boot_latency", 32'(first), 32'd2);

        // streaming
        mem_mode = 1;
        do_reset(1);
        npop = 0; fp = -1; lp = -1;
        for (int i = 0; i < 30 && npop < 8; i++) begin
            cycle();
            if (pop_s) begin
                if (fp < 0) fp = cyc - 1;
                lp = cyc - 1;
                npop++;
            end
        end
        if (npop < 8) flag("stream_pops");
        else chk("stream_back_to_back", 32'(lp - fp), 32'd7);

        // backpressure
        instr_ready = 1'b0;
        do_reset(1);
        ngnt = 0;
        repeat (10) begin
            cycle();
            if (fire_s) ngnt++;
        end
        chk("bp_grants", 32'(ngnt), 32'd4);
        chk("bp_req_off", {31'd0, req_s}, 32'd0);
        instr_ready = 1'b1;
        npop = 0; seen = 1'b0;
        for (int i = 0; i < 10 && (npop < 4 || !seen); i++) begin
            cycle();
            if (pop_s) npop++;
            if (req_s) seen = 1'b1;
        end
        if (npop < 4) flag("bp_drain");
        chk("bp_resume", {31'd0, seen}, 32'd1);

        // redirect with two fetches in flight, 3-cycle memory
        lat = 3;
        gnt_en = 1'b0;
        do_reset(1);
        gnt_en = 1'b1;
        cycle();
        cycle();
        gnt_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        chk("rd3_valid_low", {31'd0, valid_s}, 32'd0);
        chk("rd3_req_low", {31'd0, req_s}, 32'd0);
        redirect_valid = 1'b0;
        gnt_en = 1'b1;
        cycle();
        chk("rd3_req", {31'd0, req_s}, 32'd1);
        chk("rd3_addr", addr_s, 32'h0000_0100);
        wait_pop("rd3_first_pc", 32'h0000_0100);

        // redirect table, 1-cycle memory
        lat = 1;
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            repeat (3) cycle();
            redirect_valid = 1'b1;
            redirect_pc = tbl[k].rpc;
            cycle();
            chk("tbl_valid_low", {31'd0, valid_s}, 32'd0);
            redirect_valid = 1'b0;
            cycle();
            chk("tbl_addr", addr_s, tbl[k].exp_addr);
            cycle();
            chk("tbl_next", addr_s, tbl[k].exp_next);
            wait_pop("tbl_first_pc", tbl[k].exp_addr);
        end

        // asynchronous reset between edges
        repeat (4) cycle();
        #2 reset = 1'b1;
        #1;
        chk("areset_req", {31'd0, imem_req}, 32'd0);
        chk("areset_valid", {31'd0, instr_valid}, 32'd0);
        chk("areset_addr", imem_addr, RESET_PC);
        chk("areset_instr", instr, 32'h0000_0013);
        cycle();
        cycle();
        reset = 1'b0;

        // stray response with nothing outstanding
        gnt_en = 1'b0;
        force_rv = 1'b1;
        cycle();
        force_rv = 1'b0;
        cycle();
        chk("spur_valid", {31'd0, valid_s}, 32'd0);
        chk("spur_req", {31'd0, req_s}, 32'd1);
        gnt_en = 1'b1;
        wait_pop("post_reset_pc", RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
